// File: rtl/and_or_ser_pkg.sv
// rtl/and_or_ser_pkg.sv - shared state type, idle level and frame length helper for the result serializer
package and_or_ser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Bits per frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_w, input bit parity_en);
        return data_w + (parity_en ? 3 : 2);
    endfunction

endpackage

// File: rtl/and_or_result_serializer_if.sv
// rtl/and_or_result_serializer_if.sv - valid/ready result-word handshake from the selector stage
interface and_or_result_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/and_or_bit_timer.sv
// rtl/and_or_bit_timer.sv - bit-period counter, pulses wrap on the last cycle of each bit
module and_or_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic wrap
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign wrap = en & (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/and_or_result_serializer.sv
// rtl/and_or_result_serializer.sv - framed LSB-first single-pin serializer for selector results; option AND_OR_SER_PARITY_EN
module and_or_result_serializer
    import and_or_ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    and_or_result_serializer_if.slave in_if,
    output logic                      ser_out,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                frame_cnt
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shift_q;
    logic              hold_full_q;
    logic [IDX_W-1:0]  idx_q;
    logic              load;
    logic              accept;
    logic              wrap;
`ifdef AND_OR_SER_PARITY_EN
    logic              par_q;
`endif

    assign in_if.in_ready = ~hold_full_q & ena;
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign busy           = (state_q != IDLE);

    and_or_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ena & busy),
        .wrap  (wrap)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ser_out = IDLE_LEVEL;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena && hold_full_q) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                ser_out = 1'b0;
                if (wrap) state_d = DATA;
            end
            DATA: begin
                ser_out = shift_q[0];
                if (wrap && idx_q == LAST_IDX) begin
`ifdef AND_OR_SER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef AND_OR_SER_PARITY_EN
            PARITY: begin
                ser_out = par_q;
                if (wrap) state_d = STOP;
            end
`endif
            STOP: begin
                ser_out = IDLE_LEVEL;
                if (wrap) begin
                    done = 1'b1;
                    // A waiting word starts its frame with no idle gap.
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            frame_cnt   <= '0;
`ifdef AND_OR_SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else if (ena) begin
            state_q     <= state_d;
            if (accept) hold_q <= in_if.in_data;
            hold_full_q <= accept | (hold_full_q & ~load);
            if (load) begin
                shift_q <= hold_q;
                idx_q   <= '0;
`ifdef AND_OR_SER_PARITY_EN
                par_q   <= ^hold_q;
`endif
            end else if (state_q == DATA && wrap) begin
                shift_q <= shift_q >> 1;
                idx_q   <= idx_q + IDX_W'(1);
            end
            if (done) frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_and_or_result_serializer.sv
// tb/tb_and_or_result_serializer.sv - directed and randomized checks of the result serializer against a queue model
module tb_and_or_result_serializer;
    import and_or_ser_pkg::*;

`ifdef AND_OR_SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FB   = frame_bits(8, PAR_EN);
    localparam int CPB0 = 4;
    localparam int CPB1 = 1;

    int cpb [2] = '{CPB0, CPB1};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic       vld   = 1'b0;
    logic [7:0] dat   = 8'h00;

    logic       ser_o  [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic       rdy_o  [2];
    logic [7:0] cnt_o  [2];

    int n_chk    = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    and_or_result_serializer_if #(.DATA_W(8)) if0 ();
    and_or_result_serializer_if #(.DATA_W(8)) if1 ();

    assign if0.in_data  = dat;
    assign if0.in_valid = vld;
    assign if1.in_data  = dat;
    assign if1.in_valid = vld;
    assign rdy_o[0]     = if0.in_ready;
    assign rdy_o[1]     = if1.in_ready;

    and_or_result_serializer #(.CLKS_PER_BIT(CPB0), .DATA_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_if(if0),
        .ser_out(ser_o[0]), .busy(busy_o[0]), .done(done_o[0]), .frame_cnt(cnt_o[0])
    );

    and_or_result_serializer #(.CLKS_PER_BIT(CPB1), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_if(if1),
        .ser_out(ser_o[1]), .busy(busy_o[1]), .done(done_o[1]), .frame_cnt(cnt_o[1])
    );

    // Model: per DUT, the queue of line levels still to be driven, one entry per active cycle.
    bit         line [2][$];
    bit         hv   [2];
    logic [7:0] hw   [2];
    logic [7:0] cntm [2];
    bit         acc  [2];

    function automatic void push_frame(input int i, input logic [7:0] w);
        for (int r = 0; r < cpb[i]; r++) line[i].push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int r = 0; r < cpb[i]; r++) line[i].push_back(w[b]);
        if (PAR_EN)
            for (int r = 0; r < cpb[i]; r++) line[i].push_back(^w);
        for (int r = 0; r < cpb[i]; r++) line[i].push_back(1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                line[i].delete();
                hv[i]   = 1'b0;
                cntm[i] = 8'd0;
            end
        end else if (ena) begin
            for (int i = 0; i < 2; i++) begin
                acc[i] = vld && !hv[i];
                if (line[i].size() != 0) begin
                    void'(line[i].pop_front());
                    if (line[i].size() == 0) begin
                        cntm[i] = cntm[i] + 8'd1;
                        if (hv[i]) begin
                            push_frame(i, hw[i]);
                            hv[i] = 1'b0;
                        end
                    end
                end else if (hv[i]) begin
                    push_frame(i, hw[i]);
                    hv[i] = 1'b0;
                end
                if (acc[i]) begin
                    hv[i] = 1'b1;
                    hw[i] = dat;
                end
            end
        end
    end

    always @(posedge clk) cyc++;
    always @(posedge clk) if (done_o[0]) done_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ser_out[%0d]", i), 32'(ser_o[i]),
                32'(line[i].size() > 0 ? line[i][0] : 1'b1));
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(line[i].size() > 0));
            chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(ena && line[i].size() == 1));
            chk($sformatf("in_ready[%0d]", i), 32'(rdy_o[i]), 32'(ena && !hv[i]));
            chk($sformatf("frame_cnt[%0d]", i), 32'(cnt_o[i]), 32'(cntm[i]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        int   g = 0;
        logic r;
        dat = w;
        vld = 1'b1;
        do begin
            r = rdy_o[0];
            @(posedge clk);
            #1;
            g++;
        end while (!r && g < 200);
        if (!r) fail_now("send_accept");
        vld = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int g = 0;
        while (done_cnt < target && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (done_cnt < target) fail_now("wait_done");
    endtask

    task automatic cap_frame(output logic [10:0] v);
        v = '0;
        step(1);
        for (int k = 0; k < FB; k++) begin
            v[k] = ser_o[0];
            step(CPB0);
        end
    endtask

    initial begin
        logic [10:0] cap;
        int          base, t0, t1, t2;

        rst_n = 1'b0;
        step(3);
        chk("rst_ser", 32'(ser_o[0]), 1);
        chk("rst_busy", 32'(busy_o[0]), 0);
        chk("rst_rdy", 32'(rdy_o[0]), 1);
        chk("rst_cnt", 32'(cnt_o[0]), 0);
        rst_n = 1'b1;
        step(2);

        base = done_cnt;
        send(8'hA5);
        cap_frame(cap);
        chk("a5_frame", 32'(cap), PAR_EN ? 32'b10101001010 : 32'b01101001010);
        chk("a5_done", 32'(done_cnt - base), 1);
        chk("a5_cnt", 32'(cnt_o[0]), 1);

        step(2);
        base = done_cnt;
        send(8'h80);
        t0 = cyc;
        send(8'h7F);
        chk("b2b_rdy_low", 32'(rdy_o[0]), 0);
        dat = 8'h55;
        vld = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            chk("b2b_stall", 32'(rdy_o[0]), 0);
        end
        vld = 1'b0;
        wait_done(base + 1);
        t1 = cyc;
        chk("b2b_next_start", 32'(ser_o[0]), 0);
        chk("b2b_busy", 32'(busy_o[0]), 1);
        wait_done(base + 2);
        t2 = cyc;
        chk("b2b_period", 32'(t2 - t1), PAR_EN ? 44 : 40);
        chk("b2b_total", 32'(t2 - t0), PAR_EN ? 89 : 81);
        chk("b2b_cnt", 32'(cnt_o[0]), 3);
        step(3);
        chk("b2b_no_third", 32'(busy_o[0]), 0);

        step(2);
        send(8'h3C);
        step(18);
        rst_n = 1'b0;
        #1;
        chk("midrst_ser", 32'(ser_o[0]), 1);
        chk("midrst_busy", 32'(busy_o[0]), 0);
        chk("midrst_cnt", 32'(cnt_o[0]), 0);
        chk("midrst_rdy", 32'(rdy_o[0]), 1);
        step(2);
        rst_n = 1'b1;
        step(2);
        send(8'h3C);
        cap_frame(cap);
        chk("3c_frame", 32'(cap), PAR_EN ? 32'b10001111000 : 32'b01001111000);
        chk("3c_cnt", 32'(cnt_o[0]), 1);

        step(2);
        base = done_cnt;
        send(8'hA5);
        step(6);
        ena = 1'b0;
        vld = 1'b1;
        dat = 8'h11;
        for (int k = 0; k < 7; k++) begin
            step(1);
            chk("ena_hold_ser", 32'(ser_o[0]), 1);
            chk("ena_rdy", 32'(rdy_o[0]), 0);
        end
        ena = 1'b1;
        vld = 1'b0;
        step(2);
        chk("ena_bit0_tail", 32'(ser_o[0]), 1);
        step(1);
        chk("ena_bit1", 32'(ser_o[0]), 0);
        wait_done(base + 1);
        step(3);
        chk("ena_no_accept", 32'(busy_o[0]), 0);
        chk("ena_rdy_after", 32'(rdy_o[0]), 1);
        chk("ena_cnt", 32'(cnt_o[0]), 2);

        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        base = done_cnt;
        for (int k = 0; k < 256; k++) send(8'h00);
        wait_done(base + 255);
        chk("wrap_255", 32'(cnt_o[0]), 255);
        wait_done(base + 256);
        chk("wrap_0", 32'(cnt_o[0]), 0);
        chk("wrap_done", 32'(done_cnt - base), 256);

        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            ena   = ($urandom_range(0, 7) != 0);
            vld   = $urandom_range(0, 1) != 0;
            dat   = 8'($urandom);
            step(1);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        vld   = 1'b0;
        step(120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/and_or_result_serializer.md
Name: and_or_result_serializer

Overview:
- Downstream stage of the AND/OR selector. Captures its 8-bit result word {mode bit, 7-bit result} through a valid/ready handshake.
- Serializes each word onto one output pin as a framed, LSB-first bitstream at a programmable bit period, so results leave the chip on a single pin.
- A one-entry holding register lets the next word be accepted while the current frame is shifting.
- Keeps a running count of completed frames.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..255.
- DATA_W, 8, width of the captured word.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- ena  in  1  global enable; low freezes all sequential state
- in_data  in  DATA_W  result word from the selector stage: [7] = mode, [6:0] = result
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  holding register empty; the word is accepted on a cycle where in_valid & in_ready & ena
- ser_out  out  1  serial frame output; idles high
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse on the last cycle of each stop bit
- frame_cnt  out  8  completed-frame counter; wraps 255 -> 0

Behaviour:
- Reset (async, rst_n=0): ser_out=1, busy=0, done=0, frame_cnt=0, in_ready=1, holding register empty, state IDLE, bit timer 0. Reset mid-frame aborts the frame at once; ser_out returns high without waiting for a clock edge.
- in_ready = ~hold_full & ena, combinational from registered state.
- States: IDLE -> START -> DATA -> STOP, then back to IDLE, or straight to START if hold_full.
- IDLE: if hold_full, load the shift register from hold, clear hold_full, and go to START.
  - Same-edge accept and load: the new word goes into hold; the loaded word is the old one.
- Latency: word accepted at edge E (engine idle, hold empty) -> hold_full after E -> start bit appears on ser_out after edge E+1.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Each bit is driven for exactly CLKS_PER_BIT cycles.
  - State and bit advances happen on the wrap.
- START: ser_out=0.
- DATA: DATA_W bits, LSB first; 3-bit index 0..DATA_W-1.
- STOP: ser_out=1; done=1 on its final cycle; frame_cnt increments on the same edge.
- Back-to-back: if hold_full at the end of STOP, go directly to START. No idle gap; frames are contiguous at (DATA_W+2)*CLKS_PER_BIT cycles.
- Accept while busy: allowed once. in_ready then drops until the engine loads the hold.
- ena=0: timer, state, hold, counters and ser_out hold their value; no accept; done forced 0.
- Resuming ena continues the bit exactly where it stopped; no bit is shortened.
- Word content is opaque; no check on mode bit.

Optional Feature:
- Macro: AND_OR_SER_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that sends one even-parity bit (XOR of the DATA_W bits). Frame length becomes DATA_W+3 bits.
- Undefined: no PARITY state and no parity logic; frame is DATA_W+2 bits.

Decomposition:
- Shared package and_or_ser_pkg holds:
  - state typedef (IDLE, START, DATA, PARITY, STOP)
  - constant IDLE_LEVEL=1'b1
  - function frame_bits(DATA_W, parity_en)
- One sub-module, and_or_bit_timer: counter with enable, CLKS_PER_BIT parameter and wrap pulse output. The FSM, holding register and shifter stay in the top.

Test Plan:
- Single word, CLKS_PER_BIT=4: send 0xA5. ser_out = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). done pulses once, frame_cnt=1. With PARITY_EN: parity bit 0 before stop (44 cycles).
- Back-to-back: 0x80 then 0x7F offered continuously. Second word accepted during frame 1; in_ready=0 until frame 2 loads; third word stalls. Frames are contiguous: stop of frame 1 is followed immediately by start of frame 2, 80 cycles total. With PARITY_EN: parity 1 and 1.
- Reset mid-frame: assert rst_n=0 during DATA bit 3. ser_out=1 immediately (before the next edge), busy=0, frame_cnt=0, in_ready=1. After release, a fresh 0x3C frames correctly.
- ena gating: drop ena for 7 cycles mid-bit. ser_out and the bit timer freeze; the bit continues for its remaining cycles afterwards; in_valid during ena=0 is not accepted.
- Counter wrap: 256 frames of 0x00. frame_cnt reads 255 after frame 255 and 0 after frame 256; done pulses 256 times.
- CLKS_PER_BIT=1: 0xFF gives 0,1×8,1 at one cycle per bit; back-to-back frames of 10 cycles.
